// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC fetch unit: next-PC selector codes, fetch FSM
// states and the default reset vector.
package pc_fetch_unit_pkg;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0000_0000_0040_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC mux: PC+4, branch target or JALR target with bit 0
// cleared, plus the 4-byte misalignment flag (no compressed instructions).
module next_pc_select
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_masked;

  always_comb begin
    jalr_masked = jalr_target & ~XLEN'(1);
    case (pc_sel)
      PC_SEL_BRANCH: next_pc = branch_target;
      PC_SEL_JALR:   next_pc = jalr_masked;
      default:       next_pc = pc + XLEN'(4);
    endcase
    misaligned = next_pc[1];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC owner: issues instruction fetches over a valid/ready
// channel, holds the fetched instruction for decode and applies redirects.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      pc_sel,
  input  logic            pc_sel_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vector,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_addr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fetch_fault_q, fetch_fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            kill_q, kill_d;

  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic [XLEN-1:0] trap_pc;
  logic            req_fire;

  next_pc_select #(
    .XLEN (XLEN)
  ) u_next_pc_select (
    .pc            (pc_q),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .next_pc       (next_pc),
    .misaligned    (next_misaligned)
  );

  assign trap_pc  = trap_vector & ~XLEN'(3);
  assign req_fire = imem_req_valid && imem_req_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; trap_en outranks retirement in every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_d = (kill_q || trap_en) ? ST_REQ : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (trap_en) begin
          state_d = ST_REQ;
        end else if (pc_sel_valid) begin
          state_d = next_misaligned ? ST_FAULT : ST_REQ;
        end
      end
      ST_FAULT: begin
        if (trap_en) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fetch_fault_d = fetch_fault_q;
    fault_addr_d  = fault_addr_q;
    kill_d        = kill_q;

    if (trap_en) begin
      pc_d          = trap_pc;
      inst_valid_d  = 1'b0;
      fetch_fault_d = 1'b0;
      // A request already in flight must have its response squashed
      if (state_q == ST_REQ && req_fire) begin
        kill_d = 1'b1;
      end else if (state_q == ST_WAIT) begin
        kill_d = !imem_resp_valid;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              inst_d       = imem_resp_data;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (pc_sel_valid) begin
            inst_valid_d = 1'b0;
            if (next_misaligned) begin
              fetch_fault_d = 1'b1;
              fault_addr_d  = next_pc;
            end else begin
              pc_d = next_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VECTOR;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_addr_q  <= '0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fault_addr_q  <= fault_addr_d;
      kill_q        <= kill_d;
    end
  end

  // Outputs; the request is gated by reset because the FSM rests in REQ
  always_comb begin
    imem_req_valid = reset && (state_q == ST_REQ);
    imem_req_addr  = pc_q;
    inst_valid     = inst_valid_q;
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    fetch_fault    = fetch_fault_q;
    fault_addr     = fault_addr_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  localparam int unsigned XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      pc_sel;
  logic            pc_sel_valid;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_target;
  logic            trap_en;
  logic [XLEN-1:0] trap_vector;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            fetch_fault;
  logic [XLEN-1:0] fault_addr;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (64'h0000_0000_0040_0000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_sel          (pc_sel),
    .pc_sel_valid    (pc_sel_valid),
    .branch_target   (branch_target),
    .jalr_target     (jalr_target),
    .trap_en         (trap_en),
    .trap_vector     (trap_vector),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault),
    .fault_addr      (fault_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept the current request, then return data one cycle later
  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  task automatic retire(input logic [1:0] sel);
    pc_sel       = sel;
    pc_sel_valid = 1'b1;
    tick();
    pc_sel_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    pc_sel          = 2'b00;
    pc_sel_valid    = 1'b0;
    branch_target   = '0;
    jalr_target     = '0;
    trap_en         = 1'b0;
    trap_vector     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #2;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);

    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_req_addr, 64'h400000);

    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_no_req", 64'(imem_req_valid), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    chk("hold_inst_valid", 64'(inst_valid), 64'd1);
    chk("hold_inst", 64'(inst), 64'h13);
    chk("hold_inst_pc", inst_pc, 64'h400000);
    tick();
    chk("hold_stays_valid", 64'(inst_valid), 64'd1);

    retire(2'b00);
    chk("plus4_inst_valid_clr", 64'(inst_valid), 64'd0);
    chk("plus4_req_addr", imem_req_addr, 64'h400004);
    chk("plus4_req_valid", 64'(imem_req_valid), 64'd1);

    do_fetch(32'h1111_1111);
    chk("inst_pc_400004", inst_pc, 64'h400004);
    branch_target = 64'h400100;
    retire(2'b01);
    chk("branch_addr", imem_req_addr, 64'h400100);

    do_fetch(32'h2222_2222);
    retire(2'b11);
    chk("sel11_addr", imem_req_addr, 64'h400104);

    do_fetch(32'h3333_3333);
    jalr_target = 64'h400201;
    retire(2'b10);
    chk("jalr_addr", imem_req_addr, 64'h400200);
    chk("jalr_no_fault", 64'(fetch_fault), 64'd0);

    do_fetch(32'h4444_4444);
    jalr_target = 64'h400203;
    retire(2'b10);
    chk("fault_set", 64'(fetch_fault), 64'd1);
    chk("fault_addr", fault_addr, 64'h400202);
    chk("fault_no_req", 64'(imem_req_valid), 64'd0);
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    chk("fault_held", 64'(fetch_fault), 64'd1);
    chk("fault_still_no_req", 64'(imem_req_valid), 64'd0);

    trap_en     = 1'b1;
    trap_vector = 64'h8000_0007;
    tick();
    trap_en = 1'b0;
    chk("trap_fault_clr", 64'(fetch_fault), 64'd0);
    chk("trap_req_valid", 64'(imem_req_valid), 64'd1);
    chk("trap_req_addr", imem_req_addr, 64'h8000_0004);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_addr", imem_req_addr, 64'h8000_0004);
    end

    trap_en     = 1'b1;
    trap_vector = 64'h1000;
    tick();
    trap_en = 1'b0;
    chk("trap_in_req_addr", imem_req_addr, 64'h1000);
    chk("trap_in_req_valid", 64'(imem_req_valid), 64'd1);

    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    trap_en        = 1'b1;
    trap_vector    = 64'h2000;
    tick();
    trap_en = 1'b0;
    chk("kill_wait_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("killed_inst_valid", 64'(inst_valid), 64'd0);
    chk("killed_req_valid", 64'(imem_req_valid), 64'd1);
    chk("killed_req_addr", imem_req_addr, 64'h2000);

    do_fetch(32'h5555_5555);
    chk("post_kill_inst", 64'(inst), 64'h5555_5555);
    chk("post_kill_inst_pc", inst_pc, 64'h2000);
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    retire(2'b01);
    chk("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(32'h6666_6666);
    retire(2'b00);
    chk("wrap_addr", imem_req_addr, 64'd0);
    chk("wrap_no_fault", 64'(fetch_fault), 64'd0);

    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("midrst_inst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_inst", 64'(inst), 64'd0);
    chk("midrst_inst_pc", inst_pc, 64'd0);
    chk("midrst_req_addr", imem_req_addr, 64'h400000);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    @(negedge clock);
    reset = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    chk("late_resp_inst_valid", 64'(inst_valid), 64'd0);
    chk("late_resp_req_valid", 64'(imem_req_valid), 64'd1);
    chk("late_resp_req_addr", imem_req_addr, 64'h400000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
